random_range_sampler: RTL and testbench
=======================================

RANDOM_RANGE_SAMPLER -- requirements
Module: random_range_sampler

Interface
REQ-001: clk  input  1  single clock; all state updates on the rising edge.
REQ-002: rst_n  input  1  reset, synchronous, active-low.
REQ-003: rnd_in  input  32  raw pseudo-random word from the Generator stage.
REQ-004: rnd_valid  input  1  rnd_in is valid this cycle.
REQ-005: rnd_ready  output  1  block accepts rnd_in this cycle; a handshake occurs when rnd_valid and rnd_ready are both high.
REQ-006: range_in  input  32  bound R; output values lie in [0, R-1]. R=0 means pass-through of the full 32-bit word.
REQ-007: cfg_load  input  1  one-cycle strobe that latches range_in.
REQ-008: cfg_busy  output  1  high while the rejection threshold is being computed.
REQ-009: out_value  output  32  reduced random value.
REQ-010: out_valid  output  1  out_value is valid; it is held until out_ready.
REQ-011: out_ready  input  1  downstream accepts out_value.
REQ-012: reject_count  output  16  number of discarded input words; saturates.

Function
REQ-013: The block SHALL implement an FSM with states IDLE, CFG, DIV and OUT.
REQ-014: The block SHALL drive rnd_ready=1 only in IDLE, and cfg_busy=1 only in CFG.
REQ-015: The threshold SHALL be T = (2^32 - R) mod R, computed in 32-bit arithmetic as (~R+1) mod R; for R=0, T=0.
REQ-016: On cfg_load, the block SHALL latch R, clear out_valid and abort any DIV/OUT operation, discarding its word. From any state it SHALL enter CFG if R!=0, or IDLE if R=0.
REQ-017: In CFG, a restoring divider SHALL run for exactly 32 cycles, 1 quotient bit per cycle. T is stored at the end, and the FSM then enters IDLE.
REQ-018: Timing for REQ-017: cfg_load in cycle M gives cfg_busy high for cycles M+1..M+32, and rnd_ready high again in cycle M+33.
REQ-019: On a handshake in IDLE with R!=0 and rnd_in < T, the block SHALL discard the word, increment reject_count (saturating at 16'hFFFF), and remain in IDLE.
REQ-020: On a handshake in IDLE with R!=0 and rnd_in >= T, the block SHALL enter DIV and compute rnd_in mod R with the same divider in 32 cycles. It then enters OUT with out_value = remainder.
REQ-021: Latency for REQ-020: a handshake in cycle N gives out_valid high from cycle N+33.
REQ-022: On a handshake in IDLE with R=0, the block SHALL set out_value = rnd_in and enter OUT, with out_valid high in cycle N+1.
REQ-023: In OUT, out_value and out_valid SHALL stay stable until out_valid && out_ready. On that cycle the FSM returns to IDLE, and out_valid is low the next cycle.
REQ-024: The block SHALL never hold more than one word in flight and SHALL have no internal buffering beyond the OUT register.
REQ-025: For R=1, T=0 and every accepted word SHALL yield out_value=0.
REQ-026: If cfg_load and a handshake coincide, cfg_load SHALL win: the word is not consumed, because rnd_ready is deasserted from the next cycle and the handshake is ignored.

Reset
REQ-027: When rst_n=0 at a clock edge, the block SHALL set state=IDLE, R=0, T=0, out_value=0, out_valid=0, reject_count=0 and cfg_busy=0; rnd_ready=1 from the first cycle after reset.
REQ-028: Reset asserted mid-CFG or mid-DIV SHALL abandon the operation with no output produced.

Verification
REQ-029: Pass-through: after reset, rnd_in=20240301 with rnd_valid=1 -> out_value=20240301 with out_valid high in the next cycle.
REQ-030: R=10: cfg_load -> cfg_busy high for 32 cycles, T=6. Then rnd_in=5 -> reject_count=1 and no output; rnd_in=6 -> out_value=6 at N+33; rnd_in=123456789 -> out_value=9.
REQ-031: R=7 (T=4): rnd_in=3 -> rejected; rnd_in=4 -> out_value=4; rnd_in=32'hFFFFFFFF -> out_value=3.
REQ-032: Backpressure: out_ready held low for 10 cycles in OUT -> out_value and out_valid stable and rnd_ready low throughout; out_ready=1 -> return to IDLE.
REQ-033: cfg_load to R=3 asserted mid-DIV -> no output for the aborted word, cfg_busy high for 32 cycles, T=1; then rnd_in=0 -> rejected.
REQ-034: Saturation: 65536 words below T -> reject_count=16'hFFFF and no wrap; rst_n low mid-DIV -> all outputs at their reset values next cycle.

Source files
------------

// File: rtl/random_range_sampler.sv
// random_range_sampler
// Reduces raw 32-bit random words to the range [0, R-1] by rejection
// sampling followed by a modulo reduction. Words below the threshold
// T = (2^32 - R) mod R are discarded so every output value in [0, R-1]
// is equally likely. T and the modulo both come from one shared
// restoring divider that produces one bit per cycle (32 cycles per divide).
// R = 0 passes the raw word through unchanged.
//
// Ports
//   clk, rst_n    : clock, synchronous active-low reset
//   rnd_in        : raw random word; rnd_valid / rnd_ready handshake
//   range_in      : bound R, latched by the one-cycle strobe cfg_load
//   cfg_busy      : threshold computation in progress
//   out_value     : reduced value; out_valid / out_ready handshake
//   reject_count  : saturating count of discarded words
module random_range_sampler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rnd_in,
  input  logic        rnd_valid,
  output logic        rnd_ready,
  input  logic [31:0] range_in,
  input  logic        cfg_load,
  output logic        cfg_busy,
  output logic [31:0] out_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] reject_count
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 16;
  localparam int unsigned STEPS = 32;
  localparam int unsigned SW    = 5;

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_DIV, S_OUT} state_t;

  state_t        state, state_next;
  logic          rnd_ready_d, cfg_busy_d, out_valid_d;

  logic [DW-1:0] range_q;
  logic [DW-1:0] thresh_q;
  logic [DW-1:0] dividend_q;
  logic [DW-1:0] rem_q;
  logic [SW-1:0] step_q;

  logic [DW:0]   rem_shift;
  logic [DW-1:0] rem_step;
  logic          last_step;
  logic          hs;
  logic          reject;

  // One restoring-division step: remainder stays below R, so a single
  // conditional subtract keeps it in range.
  always_comb begin
    rem_shift = {rem_q, dividend_q[DW-1]};
    rem_step  = rem_shift[DW-1:0];
    if (rem_shift >= {1'b0, range_q}) begin
      rem_step = DW'(rem_shift - {1'b0, range_q});
    end
    last_step = (step_q == SW'(STEPS - 1));
    // A coinciding cfg_load suppresses the handshake entirely.
    hs        = (state == S_IDLE) && rnd_valid && !cfg_load;
    reject    = hs && (range_q != '0) && (rnd_in < thresh_q);
  end

  // State register plus registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rnd_ready <= 1'b1;
      cfg_busy  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      rnd_ready <= rnd_ready_d;
      cfg_busy  <= cfg_busy_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state logic; cfg_load overrides every state.
  always_comb begin
    state_next = state;
    if (cfg_load) begin
      state_next = (range_in != '0) ? S_CFG : S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            if (range_q == '0)  state_next = S_OUT;
            else if (!reject)   state_next = S_DIV;
          end
        end
        S_CFG:   if (last_step) state_next = S_IDLE;
        S_DIV:   if (last_step) state_next = S_OUT;
        S_OUT:   if (out_ready) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so the status flops track it.
  always_comb begin
    rnd_ready_d = (state_next == S_IDLE);
    cfg_busy_d  = (state_next == S_CFG);
    out_valid_d = (state_next == S_OUT);
  end

  // Datapath: bound, threshold, divider registers, result and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      range_q      <= '0;
      thresh_q     <= '0;
      dividend_q   <= '0;
      rem_q        <= '0;
      step_q       <= '0;
      out_value    <= '0;
      reject_count <= '0;
    end else if (cfg_load) begin
      range_q    <= range_in;
      dividend_q <= DW'(~range_in + DW'(1));
      rem_q      <= '0;
      step_q     <= '0;
      if (range_in == '0) thresh_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            if (range_q == '0) begin
              out_value <= rnd_in;
            end else if (reject) begin
              if (reject_count != {CW{1'b1}}) reject_count <= reject_count + CW'(1);
            end else begin
              dividend_q <= rnd_in;
              rem_q      <= '0;
              step_q     <= '0;
            end
          end
        end
        S_CFG: begin
          dividend_q <= {dividend_q[DW-2:0], 1'b0};
          rem_q      <= rem_step;
          step_q     <= step_q + SW'(1);
          if (last_step) thresh_q <= rem_step;
        end
        S_DIV: begin
          dividend_q <= {dividend_q[DW-2:0], 1'b0};
          rem_q      <= rem_step;
          step_q     <= step_q + SW'(1);
          if (last_step) out_value <= rem_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_random_range_sampler.sv
// Self-checking bench for random_range_sampler. Expected values come from
// plain 64-bit arithmetic on the sampling rules (threshold and modulo).
module tb_random_range_sampler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rnd_in;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [31:0] range_in;
  logic        cfg_load;
  logic        cfg_busy;
  logic [31:0] out_value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] reject_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] rc_model = 16'd0;

  always #5 clk = ~clk;

  random_range_sampler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rnd_in       (rnd_in),
    .rnd_valid    (rnd_valid),
    .rnd_ready    (rnd_ready),
    .range_in     (range_in),
    .cfg_load     (cfg_load),
    .cfg_busy     (cfg_busy),
    .out_value    (out_value),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .reject_count (reject_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_t(input logic [31:0] r);
    logic [63:0] r64;
    r64 = {32'd0, r};
    if (r == 32'd0) return 32'd0;
    return 32'((64'h1_0000_0000 - r64) % r64);
  endfunction

  function automatic logic [31:0] model_mod(input logic [31:0] w, input logic [31:0] r);
    if (r == 32'd0) return w;
    return 32'({32'd0, w} % {32'd0, r});
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Strobe cfg_load; report busy cycles and the cycle offset where rnd_ready returns.
  task automatic configure(input logic [31:0] r, output int busy, output int ready_at);
    range_in = r;
    cfg_load = 1'b1;
    tick;
    cfg_load = 1'b0;
    busy     = 0;
    ready_at = 1;
    while (!rnd_ready && ready_at < 40) begin
      if (cfg_busy) busy++;
      tick;
      ready_at++;
    end
  endtask

  // Offer one word from IDLE; lat = cycles to out_valid (0 if none within budget).
  task automatic send_word(input logic [31:0] w, output int lat, output logic [31:0] val);
    rnd_in    = w;
    rnd_valid = 1'b1;
    tick;
    rnd_valid = 1'b0;
    lat = 1;
    val = 32'd0;
    while (!out_valid && lat < 40) begin
      tick;
      lat++;
    end
    if (out_valid) begin
      val       = out_value;
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end else begin
      lat = 0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rnd_valid = 1'b0; cfg_load = 1'b0; out_ready = 1'b0;
    range_in = 32'd0; rnd_in = 32'd0;
    tick;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_value !== 32'd0) begin errors++; $display("FAIL reset_out_value got %0h exp 0", out_value); end
    checks++; if (reject_count !== 16'd0) begin errors++; $display("FAIL reset_reject_count got %0h exp 0", reject_count); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_cfg_busy got %b exp 0", cfg_busy); end
    checks++; if (rnd_ready !== 1'b1) begin errors++; $display("FAIL reset_rnd_ready got %b exp 1", rnd_ready); end
    rst_n = 1'b1;
    rc_model = 16'd0;
  endtask

  task automatic test_passthrough;
    int lat;
    logic [31:0] w, val;
    rnd_in = 32'd20240301;
    rnd_valid = 1'b1;
    tick;
    rnd_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_valid got %b exp 1", out_valid); end
    checks++; if (out_value !== 32'd20240301) begin errors++; $display("FAIL pass_value got %0d exp 20240301", out_value); end
    checks++; if (rnd_ready !== 1'b0) begin errors++; $display("FAIL pass_ready_low got %b exp 0", rnd_ready); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || rnd_ready !== 1'b1) begin errors++; $display("FAIL pass_return got valid=%b ready=%b exp 0/1", out_valid, rnd_ready); end
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      send_word(w, lat, val);
      checks++; if (lat !== 1 || val !== w) begin errors++; $display("FAIL pass_random got lat=%0d val=%0h exp lat=1 val=%0h", lat, val, w); end
    end
  endtask

  task automatic test_ranges;
    logic [31:0] rlist[6];
    logic [31:0] words[$];
    logic [31:0] r, t, w, val;
    int busy, ready_at, lat;
    rlist[0] = 32'd10;
    rlist[1] = 32'd7;
    rlist[2] = 32'd1;
    rlist[3] = 32'h8000_0001;
    rlist[4] = $urandom | 32'd1;
    rlist[5] = 32'($urandom_range(1000, 2));
    for (int k = 0; k < 6; k++) begin
      r = rlist[k];
      t = model_t(r);
      configure(r, busy, ready_at);
      checks++; if (busy !== 32 || ready_at !== 33) begin errors++; $display("FAIL cfg_timing R=%0d got busy=%0d ready_at=%0d exp 32/33", r, busy, ready_at); end
      words.delete();
      if (r == 32'd10) begin words.push_back(32'd5); words.push_back(32'd6); words.push_back(32'd123456789); end
      if (r == 32'd7)  begin words.push_back(32'd3); words.push_back(32'd4); end
      if (t != 32'd0) begin words.push_back(t - 32'd1); words.push_back($urandom % t); end
      words.push_back(t);
      words.push_back(32'hFFFF_FFFF);
      words.push_back(32'd0);
      for (int i = 0; i < 3; i++) words.push_back($urandom);
      foreach (words[i]) begin
        w = words[i];
        send_word(w, lat, val);
        if (w < t) begin
          rc_model = sat_inc(rc_model);
          checks++; if (lat !== 0 || reject_count !== rc_model) begin errors++; $display("FAIL reject R=%0d w=%0h got lat=%0d rc=%0d exp lat=0 rc=%0d", r, w, lat, reject_count, rc_model); end
        end else begin
          checks++; if (lat !== 33 || val !== model_mod(w, r) || reject_count !== rc_model) begin
            errors++; $display("FAIL reduce R=%0d w=%0h got lat=%0d val=%0d rc=%0d exp lat=33 val=%0d rc=%0d", r, w, lat, val, reject_count, 33, model_mod(w, r), rc_model);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int busy, ready_at;
    logic [31:0] w;
    configure(32'd0, busy, ready_at);
    checks++; if (busy !== 0 || ready_at !== 1) begin errors++; $display("FAIL cfg_zero got busy=%0d ready_at=%0d exp 0/1", busy, ready_at); end
    w = $urandom;
    rnd_in = w;
    rnd_valid = 1'b1;
    tick;
    rnd_valid = 1'b0;
    rnd_in = ~w;
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_valid !== 1'b1 || out_value !== w || rnd_ready !== 1'b0) begin
        errors++; $display("FAIL hold cyc=%0d got valid=%b val=%0h ready=%b exp 1/%0h/0", i, out_valid, out_value, rnd_ready, w);
      end
      tick;
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || rnd_ready !== 1'b1) begin errors++; $display("FAIL hold_release got valid=%b ready=%b exp 0/1", out_valid, rnd_ready); end
  endtask

  task automatic test_cfg_abort;
    int busy, ready_at, lat, seen;
    logic [31:0] val;
    configure(32'd10, busy, ready_at);
    rnd_in = 32'd6;
    rnd_valid = 1'b1;
    tick;
    rnd_valid = 1'b0;
    repeat (10) tick;
    configure(32'd3, busy, ready_at);
    checks++; if (busy !== 32 || ready_at !== 33) begin errors++; $display("FAIL abort_cfg got busy=%0d ready_at=%0d exp 32/33", busy, ready_at); end
    seen = 0;
    repeat (40) begin if (out_valid) seen++; tick; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_output got %0d valid cycles exp 0", seen); end
    send_word(32'd0, lat, val);
    rc_model = sat_inc(rc_model);
    checks++; if (lat !== 0 || reject_count !== rc_model) begin errors++; $display("FAIL abort_reject0 got lat=%0d rc=%0d exp 0/%0d", lat, reject_count, rc_model); end
    send_word(32'd1, lat, val);
    checks++; if (lat !== 33 || val !== 32'd1) begin errors++; $display("FAIL abort_accept1 got lat=%0d val=%0d exp 33/1", lat, val); end
    // cfg_load coinciding with a handshake wins; word 0 would otherwise be rejected.
    rnd_in = 32'd0; rnd_valid = 1'b1; range_in = 32'd3; cfg_load = 1'b1;
    tick;
    rnd_valid = 1'b0; cfg_load = 1'b0;
    checks++; if (cfg_busy !== 1'b1 || rnd_ready !== 1'b0 || reject_count !== rc_model) begin
      errors++; $display("FAIL coincide got busy=%b ready=%b rc=%0d exp 1/0/%0d", cfg_busy, rnd_ready, reject_count, rc_model);
    end
    seen = 0; lat = 0;
    while (!rnd_ready && lat < 40) begin if (out_valid) seen++; tick; lat++; end
    checks++; if (seen !== 0 || lat !== 32) begin errors++; $display("FAIL coincide_done got valid_cycles=%0d wait=%0d exp 0/32", seen, lat); end
    // cfg_load while holding an output clears it.
    configure(32'd0, busy, ready_at);
    rnd_in = 32'h1234_5678; rnd_valid = 1'b1;
    tick;
    rnd_valid = 1'b0;
    range_in = 32'd0; cfg_load = 1'b1;
    tick;
    cfg_load = 1'b0;
    checks++; if (out_valid !== 1'b0 || rnd_ready !== 1'b1) begin errors++; $display("FAIL cfg_in_out got valid=%b ready=%b exp 0/1", out_valid, rnd_ready); end
  endtask

  task automatic test_saturation;
    int busy, ready_at, bad;
    logic [31:0] t;
    configure(32'h8000_0001, busy, ready_at);
    t = model_t(32'h8000_0001);
    bad = 0;
    rnd_valid = 1'b1;
    for (int i = 0; i < 65600; i++) begin
      rnd_in = $urandom % t;
      tick;
      rc_model = sat_inc(rc_model);
      if (reject_count !== rc_model || out_valid !== 1'b0) bad++;
    end
    rnd_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL sat_track got %0d bad cycles exp 0", bad); end
    checks++; if (reject_count !== rc_model) begin errors++; $display("FAIL sat_final got %0h exp %0h", reject_count, rc_model); end
  endtask

  task automatic test_reset_mid_op;
    int busy, ready_at, lat, seen;
    logic [31:0] val, w;
    configure(32'd0, busy, ready_at);
    send_word(32'hDEAD_BEEF, lat, val);
    configure(32'd10, busy, ready_at);
    rnd_in = 32'd123456789; rnd_valid = 1'b1;
    tick;
    rnd_valid = 1'b0;
    repeat (5) tick;
    rst_n = 1'b0;
    tick;
    rc_model = 16'd0;
    checks++; if (out_valid !== 1'b0 || out_value !== 32'd0 || reject_count !== 16'd0 || cfg_busy !== 1'b0 || rnd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_div got valid=%b val=%0h rc=%0h busy=%b ready=%b exp 0/0/0/0/1", out_valid, out_value, reject_count, cfg_busy, rnd_ready);
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin if (out_valid) seen++; tick; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_div_no_output got %0d exp 0", seen); end
    // Reset mid-CFG
    range_in = 32'd9; cfg_load = 1'b1;
    tick;
    cfg_load = 1'b0;
    repeat (5) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++; if (cfg_busy !== 1'b0 || rnd_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg got busy=%b ready=%b exp 0/1", cfg_busy, rnd_ready); end
    // R returns to 0 after reset: pass-through.
    w = $urandom;
    send_word(w, lat, val);
    checks++; if (lat !== 1 || val !== w) begin errors++; $display("FAIL rst_pass got lat=%0d val=%0h exp 1/%0h", lat, val, w); end
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_ranges;
    test_backpressure;
    test_cfg_abort;
    test_saturation;
    test_reset_mid_op;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
